// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: snapshots the 8-digit display_code bus once per frame and scans it onto a
// multiplexed common-anode display with per-slot blanking; DISPLAY_DIM_EN adds a brightness duty control.
module seven_segment_scanner #(
  parameter int DIGIT_CYCLES   = 12500,
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [47:0] display_code,
`ifdef DISPLAY_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] AN_OFF = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0][5:0] r_buf;
  logic [7:0]      r_seg, r_an;
  logic            r_fs;
  logic            w_wrap, w_snap, w_drive;
  logic [7:0]      w_pat;

  function automatic logic [7:0] decode(input logic [5:0] c);
    case (c)
      6'h00: decode = 8'h3F;
      6'h01: decode = 8'h06;
      6'h02: decode = 8'h5B;
      6'h03: decode = 8'h4F;
      6'h04: decode = 8'h66;
      6'h05: decode = 8'h6D;
      6'h06: decode = 8'h7D;
      6'h07: decode = 8'h07;
      6'h08: decode = 8'h7F;
      6'h09: decode = 8'h6F;
      6'h0A: decode = 8'h77;
      6'h0B: decode = 8'h38;
      6'h0C: decode = 8'h40;
      default: decode = 8'h00;
    endcase
  endfunction

  assign w_wrap = r_cnt == LAST;
  assign w_snap = w_wrap && r_idx == 3'd7;
  assign w_pat  = decode(r_buf[r_idx]);

`ifdef DISPLAY_DIM_EN
  localparam logic [31:0] SPAN = 32'(DIGIT_CYCLES - BLANK_CYCLES);
  logic [2:0]  r_bright;
  logic [31:0] w_lim, w_on;
  assign w_lim = (SPAN * (32'(r_bright) + 32'd1)) >> 3;
  // the shortest duty still lights the digit for one cycle
  assign w_on = (w_lim == 32'd0) ? 32'd1 : w_lim;
  assign w_drive = r_cnt >= BLANK && (32'(r_cnt) - 32'(BLANK)) < w_on;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_bright <= 3'd7;
    else if (w_snap) r_bright <= brightness;
`else
  assign w_drive = r_cnt >= BLANK;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_buf <= {8{6'h3F}};
      r_fs  <= 1'b0;
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_idx <= w_wrap ? r_idx + 3'd1 : r_idx;
      if (w_snap) r_buf <= display_code;
      r_fs  <= r_cnt == '0 && r_idx == '0;
      r_an  <= w_drive ? AN_OFF ^ (8'd1 << r_idx) : AN_OFF;
      r_seg <= w_drive ? SEG_OFF ^ w_pat : SEG_OFF;
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign frame_start = r_fs;
endmodule
